// File: rtl/cpu_bus_arb_pkg.sv
// Shared types for cpu_bus_arb: arbiter state encoding, bus owner and DMA hold limit.
// The watchdog is enabled by defining CPU_BUS_ARB_WDOG_EN.
package cpu_bus_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_HANDOVER = 2'd1,
    S_DBG      = 2'd2,
    S_DMA      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    OWN_DBG = 2'd1,
    OWN_DMA = 2'd2
  } owner_e;

  localparam int DMA_MAX_CYCLES_DEF = 514;

  function automatic state_e owner_state(input owner_e own);
    case (own)
      OWN_DBG: owner_state = S_DBG;
      OWN_DMA: owner_state = S_DMA;
      default: owner_state = S_CPU;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_arb.sv
// Fixed-priority (dbg > dma > cpu) non-preemptive memory bus arbiter with one dead cycle per
// ownership change. Define CPU_BUS_ARB_WDOG_EN to bound DMA ownership with a watchdog.
module cpu_bus_arb
  import cpu_bus_arb_pkg::*;
#(
  parameter int DMA_MAX_CYCLES = DMA_MAX_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req,
  input  logic        dbg_r_nw,
  input  logic [15:0] dbg_a,
  input  logic [7:0]  dbg_dout,
  input  logic        dma_req,
  input  logic        dma_r_nw,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_dout,
  input  logic        cpu_r_nw,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic        dbg_gnt,
  output logic        dma_gnt,
  output logic        cpu_ready,
  output logic        bus_r_nw,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        wdog_err
);

  state_e      state_q, state_d;
  owner_e      pend_q, pend_d;
  logic [15:0] last_a_q, last_a_d;
  logic [7:0]  last_d_q, last_d_d;
  logic        dma_ok;
  logic        wdog_fire;

`ifdef CPU_BUS_ARB_WDOG_EN
  logic [9:0] dma_cnt_q, dma_cnt_d;
  logic       dma_lock_q, dma_lock_d;

  assign wdog_fire = (state_q == S_DMA) && (dma_cnt_q == 10'(DMA_MAX_CYCLES - 1));
  // After a forced release DMA stays locked out until its request has dropped once.
  assign dma_ok    = dma_req && !dma_lock_q;

  always_comb begin
    dma_cnt_d  = (state_q == S_DMA) ? dma_cnt_q + 10'd1 : 10'd0;
    dma_lock_d = dma_lock_q ? dma_req : wdog_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_cnt_q  <= 10'd0;
      dma_lock_q <= 1'b0;
    end else begin
      dma_cnt_q  <= dma_cnt_d;
      dma_lock_q <= dma_lock_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign dma_ok    = dma_req;
`endif

  assign wdog_err = wdog_fire;
  assign last_a_d = bus_a;
  assign last_d_d = bus_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CPU;
      pend_q   <= OWN_CPU;
      last_a_q <= 16'h0000;
      last_d_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      last_a_q <= last_a_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_CPU: begin
        if (dbg_req) begin
          state_d = S_HANDOVER;
          pend_d  = OWN_DBG;
        end else if (dma_ok) begin
          state_d = S_HANDOVER;
          pend_d  = OWN_DMA;
        end
      end
      S_HANDOVER: state_d = owner_state(pend_q);
      S_DBG: begin
        if (!dbg_req) begin
          state_d = S_HANDOVER;
          pend_d  = dma_ok ? OWN_DMA : OWN_CPU;
        end
      end
      default: begin
        if (!dma_req || wdog_fire) begin
          state_d = S_HANDOVER;
          pend_d  = dbg_req ? OWN_DBG : OWN_CPU;
        end
      end
    endcase
  end

  // Handover holds the previous owner's address/data and forces a read.
  always_comb begin
    cpu_ready = 1'b0;
    dbg_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    bus_r_nw  = 1'b1;
    bus_a     = last_a_q;
    bus_dout  = last_d_q;
    case (state_q)
      S_CPU: begin
        cpu_ready = 1'b1;
        bus_r_nw  = cpu_r_nw;
        bus_a     = cpu_a;
        bus_dout  = cpu_dout;
      end
      S_DBG: begin
        dbg_gnt  = 1'b1;
        bus_r_nw = dbg_r_nw;
        bus_a    = dbg_a;
        bus_dout = dbg_dout;
      end
      S_DMA: begin
        dma_gnt  = 1'b1;
        bus_r_nw = dma_r_nw;
        bus_a    = dma_a;
        bus_dout = dma_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Directed self-checking bench for cpu_bus_arb; watchdog checks follow CPU_BUS_ARB_WDOG_EN.
module tb_cpu_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req, dbg_r_nw, dma_req, dma_r_nw, cpu_r_nw;
  logic [15:0] dbg_a, dma_a, cpu_a;
  logic [7:0]  dbg_dout, dma_dout, cpu_dout;
  logic        dbg_gnt, dma_gnt, cpu_ready, bus_r_nw, wdog_err;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;

  int vecs = 0;
  int errs = 0;

  always #10 clk = ~clk;

  cpu_bus_arb #(.DMA_MAX_CYCLES(514)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .dbg_r_nw(dbg_r_nw), .dbg_a(dbg_a), .dbg_dout(dbg_dout),
    .dma_req(dma_req), .dma_r_nw(dma_r_nw), .dma_a(dma_a), .dma_dout(dma_dout),
    .cpu_r_nw(cpu_r_nw), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
    .dbg_gnt(dbg_gnt), .dma_gnt(dma_gnt), .cpu_ready(cpu_ready),
    .bus_r_nw(bus_r_nw), .bus_a(bus_a), .bus_dout(bus_dout), .wdog_err(wdog_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // owner: 0 = cpu, 1 = handover, 2 = dbg, 3 = dma
  task automatic chk_own(input string tag, input int owner);
    chk({tag, ".cpu_ready"}, {15'd0, cpu_ready}, {15'd0, owner == 0});
    chk({tag, ".dbg_gnt"},   {15'd0, dbg_gnt},   {15'd0, owner == 2});
    chk({tag, ".dma_gnt"},   {15'd0, dma_gnt},   {15'd0, owner == 3});
  endtask

  initial begin
    rst = 1'b1;
    dbg_req = 1'b0; dbg_r_nw = 1'b1; dbg_a = 16'h2222; dbg_dout = 8'hD0;
    dma_req = 1'b0; dma_r_nw = 1'b1; dma_a = 16'h3333; dma_dout = 8'hA0;
    cpu_r_nw = 1'b1; cpu_a = 16'h1111; cpu_dout = 8'hC0;
    tick();
    tick();
    chk_own("reset", 0);
    chk("reset.bus_r_nw", {15'd0, bus_r_nw}, 16'd1);
    chk("reset.wdog_err", {15'd0, wdog_err}, 16'd0);
    rst = 1'b0;

    // Idle: bus follows the CPU every cycle
    for (int i = 0; i < 10; i++) begin
      cpu_a = 16'h4000 + 16'(i * 7);
      #1;
      chk("idle.bus_a", bus_a, 16'h4000 + 16'(i * 7));
      chk("idle.cpu_ready", {15'd0, cpu_ready}, 16'd1);
      tick();
    end
    $display("idle: 10 cycles done");

    // DBG request while the CPU is writing
    cpu_a = 16'h1111; cpu_r_nw = 1'b0; dbg_r_nw = 1'b0;
    dbg_req = 1'b1;
    #1;
    chk("dbg.n.bus_r_nw", {15'd0, bus_r_nw}, 16'd0);
    tick();
    chk_own("dbg.n1", 1);
    chk("dbg.n1.bus_r_nw", {15'd0, bus_r_nw}, 16'd1);
    chk("dbg.n1.bus_a", bus_a, 16'h1111);
    chk("dbg.n1.bus_dout", {8'd0, bus_dout}, 16'h00C0);
    tick();
    chk_own("dbg.n2", 2);
    chk("dbg.n2.bus_a", bus_a, 16'h2222);
    chk("dbg.n2.bus_r_nw", {15'd0, bus_r_nw}, 16'd0);
    dbg_req = 1'b0;
    tick();
    chk_own("dbg.rel", 1);
    chk("dbg.rel.bus_a", bus_a, 16'h2222);
    chk("dbg.rel.bus_r_nw", {15'd0, bus_r_nw}, 16'd1);
    tick();
    chk_own("dbg.cpu", 0);
    cpu_r_nw = 1'b1; dbg_r_nw = 1'b1;
    $display("dbg burst: done");

    // Simultaneous requests: DBG first, then DMA
    dbg_req = 1'b1; dma_req = 1'b1;
    tick();
    chk_own("both.ho1", 1);
    tick();
    chk_own("both.dbg", 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_own("both.dbg_hold", 2);
    end
    dbg_req = 1'b0;
    tick();
    chk_own("both.ho2", 1);
    tick();
    chk_own("both.dma", 3);
    chk("both.dma.bus_a", bus_a, 16'h3333);
    dma_req = 1'b0;
    tick();
    chk_own("both.ho3", 1);
    tick();
    chk_own("both.cpu", 0);
    $display("simultaneous dbg+dma: done");

    // DMA is not preempted by DBG
    dma_req = 1'b1;
    tick();
    tick();
    chk_own("nopre.dma", 3);
    dbg_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_own("nopre.dma_hold", 3);
    end
    dma_req = 1'b0;
    tick();
    chk_own("nopre.ho", 1);
    tick();
    chk_own("nopre.dbg", 2);
    dbg_req = 1'b0;
    tick();
    tick();
    chk_own("nopre.cpu", 0);
    $display("non-preemption: done");

    // Long DMA burst
    dma_req = 1'b1;
    tick();
    chk_own("long.ho", 1);
`ifdef CPU_BUS_ARB_WDOG_EN
    for (int k = 1; k <= 514; k++) begin
      tick();
      chk("long.dma_gnt", {15'd0, dma_gnt}, 16'd1);
      chk("long.wdog_err", {15'd0, wdog_err}, {15'd0, k == 514});
    end
    tick();
    chk_own("wdog.ho", 1);
    chk("wdog.ho.wdog_err", {15'd0, wdog_err}, 16'd0);
    for (int k = 0; k < 80; k++) begin
      tick();
      chk_own("wdog.locked", 0);
    end
    dma_req = 1'b0;
    tick();
    dma_req = 1'b1;
    tick();
    chk_own("wdog.regrant_ho", 1);
    tick();
    chk_own("wdog.regrant", 3);
    $display("watchdog release and lockout: done");
`else
    for (int k = 1; k <= 600; k++) begin
      tick();
      chk("long.dma_gnt", {15'd0, dma_gnt}, 16'd1);
      chk("long.wdog_err", {15'd0, wdog_err}, 16'd0);
    end
    $display("unbounded dma burst: done");
`endif
    dma_req = 1'b0;
    tick();
    tick();
    chk_own("long.cpu", 0);

    // Reset in the middle of a DBG write
    dbg_req = 1'b1; dbg_r_nw = 1'b0;
    tick();
    tick();
    chk_own("rstmid.dbg", 2);
    chk("rstmid.write", {15'd0, bus_r_nw}, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; dbg_req = 1'b0;
    chk_own("rstmid.after", 0);
    chk("rstmid.bus_r_nw", {15'd0, bus_r_nw}, 16'd1);
    chk("rstmid.bus_a", bus_a, 16'h1111);
    tick();
    chk_own("rstmid.no_ho", 0);
    $display("reset mid-burst: done");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
